// File: rtl/rand_spawner_pkg.sv
// Shared types and constants for the enemy spawner: FSM states, widths and
// the bit-field layout of the 20-bit LFSR word.
package rand_spawner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    OFFER  = 2'd3
  } state_e;

  localparam int RND_W = 20;
  localparam int X_W   = 10;

  localparam int X_LSB     = 0;
  localparam int X_MSB     = 9;
  localparam int KIND_LSB  = 10;
  localparam int KIND_MSB  = 11;
  localparam int SPEED_LSB = 12;
  localparam int SPEED_MSB = 13;
  localparam int GAP_LSB   = 15;
  localparam int GAP_MSB   = 19;

  localparam int REPEAT_DIST = 64;

  function automatic logic [X_W-1:0] abs_diff(input logic [X_W-1:0] a,
                                               input logic [X_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/rand_spawner_sampler.sv
// Combinational candidate check and payload extraction for one random word.
// SPAWN_AVOID_REPEAT_EN adds rejection of X positions near the last spawn.
module spawn_sampler
  import rand_spawner_pkg::*;
#(
  parameter int X_RANGE  = 600,
  parameter int X_OFFSET = 20
) (
  input  logic [SPEED_MSB:0] rnd_i,
`ifdef SPAWN_AVOID_REPEAT_EN
  input  logic [X_W-1:0]     last_x_i,
`endif
  output logic               accept_o,
  output logic [X_W-1:0]     cand_x_o,
  output logic [X_W-1:0]     fb_x_o,
  output logic [1:0]         kind_o,
  output logic [2:0]         speed_o
);

  localparam logic [X_W:0]   X_RANGE_C  = (X_W+1)'(X_RANGE);
  localparam logic [X_W-1:0] X_OFFSET_C = X_W'(X_OFFSET);

  logic in_range;

  // NOTE: only continuous assigns here, so every output is always driven and no latch can form.
  assign in_range = {1'b0, rnd_i[X_MSB:X_LSB]} < X_RANGE_C;
  assign cand_x_o = X_OFFSET_C + rnd_i[X_MSB:X_LSB];
  // Fallback drops the X MSB so the sample is < 512 and always on screen.
  assign fb_x_o   = X_OFFSET_C + {1'b0, rnd_i[X_MSB-1:X_LSB]};
  assign kind_o   = rnd_i[KIND_MSB:KIND_LSB];
  assign speed_o  = 3'd1 + {1'b0, rnd_i[SPEED_MSB:SPEED_LSB]};

`ifdef SPAWN_AVOID_REPEAT_EN
  assign accept_o = in_range &&
                    (abs_diff(cand_x_o, last_x_i) >= X_W'(REPEAT_DIST));
`else
  assign accept_o = in_range;
`endif

endmodule

// File: rtl/rand_spawner.sv
// Turns the free-running LFSR word into timed enemy spawn requests with a
// difficulty ramp. Optional macro: SPAWN_AVOID_REPEAT_EN (no repeat X).
module rand_spawner
  import rand_spawner_pkg::*;
#(
  parameter int X_RANGE   = 600,
  parameter int X_OFFSET  = 20,
  parameter int GAP_MIN   = 30,
  parameter int GAP_FLOOR = 8,
  parameter int MAX_TRIES = 8,
  parameter int DIFF_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RND_W-1:0] rnd,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             spawn_ready,
  output logic             spawn_valid,
  output logic [X_W-1:0]   spawn_x,
  output logic [1:0]       spawn_kind,
  output logic [2:0]       spawn_speed,
  output logic [7:0]       gap_min
);

  localparam logic [7:0] GAP_MIN_C   = 8'(GAP_MIN);
  localparam logic [7:0] GAP_FLOOR_C = 8'(GAP_FLOOR);
  localparam logic [7:0] TRY_LAST    = 8'(MAX_TRIES - 1);
  localparam logic [7:0] STEP_LAST   = 8'(DIFF_STEP - 1);

  state_e         state_q;
  logic [7:0]     gap_cnt_q;
  logic [7:0]     try_q;
  logic [7:0]     step_q;
  logic [7:0]     gap_min_q;
  logic           valid_q;
  logic [X_W-1:0] x_q;
  logic [1:0]     kind_q;
  logic [2:0]     speed_q;

  logic           accept;
  logic [X_W-1:0] cand_x;
  logic [X_W-1:0] fb_x;
  logic [1:0]     kind;
  logic [2:0]     speed;

  logic           xfer;
  logic [7:0]     gap_ramp;
  logic [7:0]     gap_min_d;
  logic [7:0]     gap_load_d;
  logic           unused_rnd;

  assign unused_rnd = rnd[GAP_LSB-1];

`ifdef SPAWN_AVOID_REPEAT_EN
  logic [X_W-1:0] last_x_q;
`endif

  spawn_sampler #(
    .X_RANGE  (X_RANGE),
    .X_OFFSET (X_OFFSET)
  ) u_sampler (
    .rnd_i    (rnd[SPEED_MSB:0]),
`ifdef SPAWN_AVOID_REPEAT_EN
    .last_x_i (last_x_q),
`endif
    .accept_o (accept),
    .cand_x_o (cand_x),
    .fb_x_o   (fb_x),
    .kind_o   (kind),
    .speed_o  (speed)
  );

  // The ramp step is folded into the reload so a transfer uses the new gap.
  assign xfer       = (state_q == OFFER) && spawn_ready;
  assign gap_ramp   = (gap_min_q >= GAP_FLOOR_C + 8'd2) ? (gap_min_q - 8'd2) : GAP_FLOOR_C;
  assign gap_min_d  = (xfer && step_q == STEP_LAST) ? gap_ramp : gap_min_q;
  assign gap_load_d = gap_min_d + {3'b000, rnd[GAP_MSB:GAP_LSB]};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      try_q     <= '0;
      step_q    <= '0;
      gap_min_q <= GAP_MIN_C;
      valid_q   <= 1'b0;
      x_q       <= '0;
      kind_q    <= '0;
      speed_q   <= '0;
`ifdef SPAWN_AVOID_REPEAT_EN
      last_x_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            gap_cnt_q <= gap_load_d;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if ((frame_tick && gap_cnt_q == 8'd1) || gap_cnt_q == 8'd0) begin
            try_q   <= '0;
            state_q <= SAMPLE;
          end else if (frame_tick) begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        SAMPLE: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (accept || try_q == TRY_LAST) begin
            x_q     <= accept ? cand_x : fb_x;
            kind_q  <= kind;
            speed_q <= speed;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end else begin
            try_q <= try_q + 8'd1;
          end
        end
        OFFER: begin
          // A pending request is never withdrawn; enable only picks the exit.
          if (spawn_ready) begin
            valid_q   <= 1'b0;
            step_q    <= (step_q == STEP_LAST) ? 8'd0 : step_q + 8'd1;
            gap_min_q <= gap_min_d;
            gap_cnt_q <= gap_load_d;
            state_q   <= enable ? WAIT : IDLE;
`ifdef SPAWN_AVOID_REPEAT_EN
            last_x_q  <= x_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_x     = x_q;
  assign spawn_kind  = kind_q;
  assign spawn_speed = speed_q;
  assign gap_min     = gap_min_q;

endmodule

// File: tb/tb_rand_spawner.sv
// Self-checking bench for rand_spawner: directed corner cases plus a long
// randomized run against a transaction-level reference model.
module tb_rand_spawner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] rnd;
  logic        frame_tick;
  logic        enable;
  logic        spawn_ready;
  logic        spawn_valid;
  logic [9:0]  spawn_x;
  logic [1:0]  spawn_kind;
  logic [2:0]  spawn_speed;
  logic [7:0]  gap_min;

  int checks = 0;
  int errors = 0;

  bit         rand_on = 1'b0;
  bit         m_on    = 1'b0;
  logic       m_valid = 1'b0;
  logic [9:0] m_x;
  logic [1:0] m_kind;
  logic [2:0] m_speed;
  int         m_gm;
  int         m_xfers;

  rand_spawner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rnd         (rnd),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_x     (spawn_x),
    .spawn_kind  (spawn_kind),
    .spawn_speed (spawn_speed),
    .gap_min     (gap_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one spawn = wait the gap in frames, draw up to 8 samples,
  // then hold the offer until ready. Inputs are read at the active edge.
  task automatic model_run(input int n);
    int          gap;
    int          budget;
    logic [19:0] r;
    @(posedge clk);
    gap = m_gm + int'(rnd[19:15]);
    for (int k = 0; k < n; k++) begin
      budget = 0;
      forever begin
        @(posedge clk);
        budget++;
        if (gap == 0 || (frame_tick && gap == 1)) break;
        if (frame_tick) gap--;
        if (budget > 5000) begin
          check("model_wait_timeout", 0, 1);
          return;
        end
      end
      for (int t = 0; t < 8; t++) begin
        @(posedge clk);
        r       = rnd;
        m_kind  = r[11:10];
        m_speed = 3'd1 + {1'b0, r[13:12]};
        if (r[9:0] < 10'd600) begin
          m_x = 10'd20 + r[9:0];
          break;
        end
        if (t == 7) m_x = 10'd20 + {1'b0, r[8:0]};
      end
      m_valid = 1'b1;
      budget  = 0;
      do begin
        @(posedge clk);
        budget++;
        if (budget > 5000) begin
          check("model_ready_timeout", 0, 1);
          return;
        end
      end while (!spawn_ready);
      m_valid = 1'b0;
      m_xfers++;
      if (m_xfers % 16 == 0) m_gm = (m_gm - 2 < 8) ? 8 : m_gm - 2;
      gap = m_gm + int'(rnd[19:15]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rand_on) begin
      rnd         = $urandom;
      frame_tick  = ($urandom_range(0, 3) != 0);
      spawn_ready = 1'($urandom_range(0, 1));
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      check("rand_valid", spawn_valid, m_valid);
      if (m_valid) begin
        check("rand_x", spawn_x, m_x);
        check("rand_kind", spawn_kind, m_kind);
        check("rand_speed", spawn_speed, m_speed);
      end
      check("rand_gap_min", gap_min, m_gm);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_tick  = 1'b0;
    spawn_ready = 1'b0;
    rnd         = 20'h00123;
    repeat (3) @(negedge clk);
    check("rst_valid", spawn_valid, 0);
    check("rst_gap_min", gap_min, 30);
    check("rst_x", spawn_x, 0);
    check("rst_kind", spawn_kind, 0);
    check("rst_speed", spawn_speed, 0);

    // Accept path: gap 30 + rnd[19:15]=0, sample 0x123.
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (30) @(negedge clk);
    frame_tick = 1'b0;
    check("acc_not_early", spawn_valid, 0);
    @(negedge clk);
    check("acc_valid", spawn_valid, 1);
    check("acc_x", spawn_x, 311);
    check("acc_kind", spawn_kind, 0);
    check("acc_speed", spawn_speed, 1);

    // Backpressure: payload frozen while rnd churns.
    for (int i = 0; i < 10; i++) begin
      rnd        = $urandom;
      frame_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", spawn_valid, 1);
      check("bp_x", spawn_x, 311);
      check("bp_kind", spawn_kind, 0);
      check("bp_speed", spawn_speed, 1);
    end
    rnd         = 20'h003FF;
    frame_tick  = 1'b0;
    spawn_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_drop", spawn_valid, 0);
    spawn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_dup", spawn_valid, 0);
    end

    // Fallback: eight rejected samples of 0x3FF.
    frame_tick = 1'b1;
    repeat (30) @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("fb_pending", spawn_valid, 0);
    end
    @(negedge clk);
    check("fb_valid", spawn_valid, 1);
    check("fb_x", spawn_x, 531);
    check("fb_kind", spawn_kind, 0);
    check("fb_speed", spawn_speed, 1);
    check("fb_gap_min", gap_min, 30);
    spawn_ready = 1'b1;
    @(negedge clk);
    check("fb_xfer_drop", spawn_valid, 0);
    spawn_ready = 1'b0;

    // Randomized run long enough to ramp gap_min down to the floor.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_gm    = 30;
    m_xfers = 0;
    m_valid = 1'b0;
    enable  = 1'b1;
    rand_on = 1'b1;
    m_on    = 1'b1;
    model_run(260);
    m_on = 1'b0;
    @(negedge clk);
    check("ramp_floor", gap_min, 8);

    // Reset mid-offer takes effect without a clock edge.
    rand_on     = 1'b0;
    spawn_ready = 1'b0;
    frame_tick  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rnd = $urandom;
      if (spawn_valid) break;
    end
    check("mid_offer_reached", spawn_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", spawn_valid, 0);
    check("async_rst_gap_min", gap_min, 30);
    check("async_rst_x", spawn_x, 0);

    // Dropping enable in WAIT returns to IDLE; ticks then spawn nothing.
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rnd = $urandom;
      @(negedge clk);
      check("disabled_idle", spawn_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_spawner.md
Name: rand_spawner

Overview:
- Consumer end of the 20-bit LFSR random stream. Samples the free-running 20-bit random word each clock and turns it into timed enemy spawn requests.
- A request carries an X position, an enemy kind and a speed, and is offered to the game-logic block over a valid/ready handshake.
- Sits between the PRNG and the enemy object table. Difficulty ramps by shortening the spawn gap as spawns are accepted.

Parameters:
- X_RANGE, 600: number of legal X positions; accepted sample must be < X_RANGE; must be >= 512 and <= 1024.
- X_OFFSET, 20: added to the accepted sample to form spawn_x.
- GAP_MIN, 30: initial minimum frames between spawns; range 1..223.
- GAP_FLOOR, 8: lowest value the minimum gap may ramp down to; 1 <= GAP_FLOOR <= GAP_MIN.
- MAX_TRIES, 8: rejection-sampling attempts before fallback.
- DIFF_STEP, 16: accepted spawns per difficulty step.

Ports:
- clk, input, 1: 50 MHz system clock.
- rst_n, input, 1: asynchronous active-low reset.
- rnd, input, 20: LFSR output; changes every clk.
- frame_tick, input, 1: one-clk pulse per video frame.
- enable, input, 1: game running.
- spawn_ready, input, 1: consumer can accept a request.
- spawn_valid, output, 1: request pending.
- spawn_x, output, 10: X_OFFSET + sample.
- spawn_kind, output, 2: enemy type.
- spawn_speed, output, 3: pixels per frame, 1..4.
- gap_min, output, 8: current minimum gap (debug/HUD).

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE, spawn_valid=0, spawn_x=0, spawn_kind=0, spawn_speed=0.
  - gap_min=GAP_MIN, gap counter=0, try counter=0, step counter=0.
- State IDLE:
  - If enable=1: load gap counter = gap_min + rnd[19:15] (8-bit, no overflow by parameter range), then go to WAIT.
- State WAIT:
  - Counter decrements only on frame_tick.
  - If frame_tick=1 and counter==1, or counter==0: go to SAMPLE, with try counter=0.
  - If enable=0: go to IDLE (takes priority over frame_tick).
- State SAMPLE (one attempt per clk; rnd is fresh each clk):
  - Accept if rnd[9:0] < X_RANGE. On accept, latch:
    - spawn_x = X_OFFSET + rnd[9:0]
    - spawn_kind = rnd[11:10]
    - spawn_speed = 1 + rnd[13:12]
    - then go to OFFER.
  - On reject: increment try counter.
  - When the try counter reaches MAX_TRIES-1 and that attempt also rejects, latch spawn_x = X_OFFSET + rnd[8:0] (always legal), with kind and speed derived as above, and go to OFFER.
  - Worst-case latency from due to spawn_valid: MAX_TRIES clks.
  - If enable=0: go to IDLE with no request.
- State OFFER:
  - spawn_valid=1; payload held stable until transfer.
  - Transfer occurs on a clk where spawn_valid & spawn_ready.
  - On transfer, in the same cycle:
    - spawn_valid drops to 0.
    - step counter increments.
    - If step counter reaches DIFF_STEP: reset it to 0 and set gap_min = max(gap_min-2, GAP_FLOOR).
    - Reload the gap counter from the new gap_min + rnd[19:15].
    - Go to WAIT, or IDLE if enable=0.
  - enable=0 while in OFFER does not withdraw a request; the handshake completes first.
- spawn_ready while spawn_valid=0 is ignored.
- frame_tick outside WAIT is ignored; no tick backlog is kept.
- gap_min persists across enable toggles; only rst_n restores it.

Optional Feature:
- Macro: SPAWN_AVOID_REPEAT_EN.
- With the macro defined:
  - Keeps the last transferred spawn_x (reset 0).
  - SAMPLE additionally rejects candidates with |candidate - last_x| < 64 (10-bit compare).
  - The fallback path still applies after MAX_TRIES, with no distance check.
- Without the macro: no last_x register; acceptance depends only on X_RANGE.

Decomposition:
- Shared package holds:
  - state enum IDLE/WAIT/SAMPLE/OFFER (2-bit encoding);
  - width constants RND_W=20, X_W=10;
  - rnd bit-field positions: X [9:0], KIND [11:10], SPEED [13:12], GAP [19:15].
- One natural sub-module: spawn_sampler. Purely combinational: X_RANGE/repeat accept check plus field extraction, producing accept, x, kind and speed.
- FSM, counters and difficulty ramp stay in rand_spawner.

Test Plan:
1. Reset mid-OFFER: drop rst_n while spawn_valid=1 -> spawn_valid=0 and gap_min=30 immediately, without waiting for a clk edge.
2. Accept path: enable=1 with rnd[19:15]=0 at load, then 30 frame_ticks, with rnd=20'h00123 at SAMPLE and ready=1.
   -> spawn_valid one clk after due; spawn_x=0x123+20=311; kind=0; speed=1.
3. Fallback: hold rnd[9:0]=1023 for 8 clks in SAMPLE, with rnd=20'h003FF.
   -> spawn_valid after the 8th attempt; spawn_x=20+511=531.
4. Backpressure: ready=0 for 10 clks while rnd changes.
   -> spawn_valid stays 1 and payload stays constant; one transfer when ready=1; no duplicate.
5. Difficulty: 16 accepted transfers -> gap_min=28; then 64 more with the ramp continuing -> gap_min never drops below 8.
6. With SPAWN_AVOID_REPEAT_EN defined: last_x=300, candidates at sample 290 then 400.
   -> 290 rejected, 400 accepted; spawn_x=420.
